// File: rtl/tone_arbiter.sv
// tone_arbiter
//   Shares one tone generator between three requesters. Bit 0 has the
//   highest priority and bit 2 the lowest (song player). An owner keeps the
//   generator until it releases its request, or until a higher-priority
//   request shows up after the owner has held for min_hold_p cycles. Every
//   release or handoff is followed by gap_cycles_p silent cycles.
//
// Ports
//   clk_i      clock, all state changes on the rising edge
//   reset_i    synchronous, active-high reset
//   req_i      [2:0] level-sensitive tone requests
//   fstep_i    [3*width_p-1:0] frequency steps; requester k at [k*width_p +: width_p]
//   grant_o    [2:0] one-hot owner, zero when nobody owns the generator
//   fstep_o    [width_p-1:0] step to the tone generator, zero is silence
//   preempt_o  one-cycle pulse on the first silent cycle after a preemption
module tone_arbiter #(
    parameter int width_p      = 32,
    parameter int min_hold_p   = 16,
    parameter int gap_cycles_p = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [2:0]             req_i,
    input  logic [3*width_p-1:0]   fstep_i,
    output logic [2:0]             grant_o,
    output logic [width_p-1:0]     fstep_o,
    output logic                   preempt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam logic [15:0] MIN_HOLD = 16'(min_hold_p);
    localparam logic [15:0] GAP_LAST = 16'(gap_cycles_p - 1);

    state_e             state_q,   state_d;
    logic [2:0]         grant_q,   grant_d;
    logic [width_p-1:0] fstep_q,   fstep_d;
    logic               preempt_q, preempt_d;
    logic [15:0]        hold_q,    hold_d;
    logic [15:0]        gap_q,     gap_d;

    logic [2:0]         pick;
    logic [width_p-1:0] pick_fstep;
    logic [width_p-1:0] own_fstep;
    logic               owner_req;
    logic               higher_req;

    // req & -req isolates the lowest set bit, i.e. the winning requester.
    assign pick = req_i & (~req_i + 3'd1);

    always_comb begin
        pick_fstep = '0;
        own_fstep  = '0;
        for (int k = 0; k < 3; k++) begin
            if (pick[k])    pick_fstep = fstep_i[k*width_p +: width_p];
            if (grant_q[k]) own_fstep  = fstep_i[k*width_p +: width_p];
        end
    end

    // grant_q - 1 on a one-hot value masks every bit below the owner,
    // which are exactly the higher-priority requesters.
    assign owner_req  = |(req_i & grant_q);
    assign higher_req = |(req_i & (grant_q - 3'd1));

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        fstep_d   = fstep_q;
        preempt_d = 1'b0;
        hold_d    = hold_q;
        gap_d     = gap_q;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                fstep_d = '0;
                if (|req_i) begin
                    state_d = OWN;
                    grant_d = pick;
                    fstep_d = pick_fstep;
                    hold_d  = '0;
                end
            end

            OWN: begin
                if (!owner_req) begin
                    // Release wins over any simultaneous preemption.
                    state_d = GAP;
                    grant_d = '0;
                    fstep_d = '0;
                    gap_d   = '0;
                end else if (higher_req && hold_q == MIN_HOLD) begin
                    state_d   = GAP;
                    grant_d   = '0;
                    fstep_d   = '0;
                    gap_d     = '0;
                    preempt_d = 1'b1;
                end else begin
                    fstep_d = own_fstep;
                    if (hold_q != MIN_HOLD) hold_d = hold_q + 16'd1;
                end
            end

            GAP: begin
                grant_d = '0;
                fstep_d = '0;
                if (gap_q == GAP_LAST) begin
                    gap_d = '0;
                    if (|req_i) begin
                        state_d = OWN;
                        grant_d = pick;
                        fstep_d = pick_fstep;
                        hold_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                fstep_d = '0;
                hold_d  = '0;
                gap_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            fstep_q   <= '0;
            preempt_q <= 1'b0;
            hold_q    <= '0;
            gap_q     <= '0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            fstep_q   <= fstep_d;
            preempt_q <= preempt_d;
            hold_q    <= hold_d;
            gap_q     <= gap_d;
        end
    end

    assign grant_o   = grant_q;
    assign fstep_o   = fstep_q;
    assign preempt_o = preempt_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Bench for tone_arbiter: a cycle model driven by integer owner/hold/gap
// bookkeeping is compared against the DUT every cycle, and directed
// scenarios pin key cycles with literal expectations.
module tb_tone_arbiter;

    localparam int W    = 32;
    localparam int HOLD = 8;
    localparam int GAPN = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req;
    logic [W-1:0]  fs [3];
    logic [3*W-1:0] fstep_bus;
    logic [2:0]    grant;
    logic [W-1:0]  fstep;
    logic          preempt;

    assign fstep_bus = {fs[2], fs[1], fs[0]};

    always #5 clk = ~clk;

    tone_arbiter #(.width_p(W), .min_hold_p(HOLD), .gap_cycles_p(GAPN)) dut (
        .clk_i    (clk),
        .reset_i  (rst),
        .req_i    (req),
        .fstep_i  (fstep_bus),
        .grant_o  (grant),
        .fstep_o  (fstep),
        .preempt_o(preempt)
    );

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int           m_owner    = -1;  // -1 means nobody owns
    int           m_held     = 0;   // OWN cycles completed before this one
    int           m_gap_left = 0;   // silent cycles remaining, this one included
    logic [W-1:0] m_fstep    = '0;
    bit           m_pre      = 1'b0;

    task automatic m_arbitrate();
        m_owner = -1;
        m_fstep = '0;
        for (int k = 0; k < 3; k++)
            if (req[k] && m_owner < 0) begin
                m_owner = k;
                m_held  = 0;
                m_fstep = fs[k];
            end
    endtask

    always @(posedge clk) begin
        bit higher;
        m_pre = 1'b0;
        if (rst) begin
            m_owner = -1; m_gap_left = 0; m_fstep = '0; m_held = 0;
        end else if (m_gap_left > 0) begin
            if (m_gap_left == 1) begin
                m_gap_left = 0;
                m_arbitrate();
            end else m_gap_left--;
        end else if (m_owner >= 0) begin
            higher = 1'b0;
            for (int j = 0; j < m_owner; j++) if (req[j]) higher = 1'b1;
            if (!req[m_owner]) begin
                m_owner = -1; m_fstep = '0; m_gap_left = GAPN;
            end else if (higher && m_held >= HOLD) begin
                m_owner = -1; m_fstep = '0; m_gap_left = GAPN; m_pre = 1'b1;
            end else begin
                m_held++;
                m_fstep = fs[m_owner];
            end
        end else m_arbitrate();
    end

    always @(negedge clk) begin
        logic [2:0] eg;
        if (chk_en) begin
            eg = (m_owner >= 0) ? 3'(1 << m_owner) : 3'b000;
            chk("model_grant",   32'(grant),   32'(eg));
            chk("model_fstep",   fstep,        m_fstep);
            chk("model_preempt", 32'(preempt), 32'(m_pre));
            chk("grant_onehot",  32'($countones(grant) <= 1), 32'd1);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        req = 3'b000;
        tick(GAPN + 2);
    endtask

    initial begin
        rst = 1'b1; req = 3'b000;
        fs[0] = '0; fs[1] = '0; fs[2] = '0;
        tick(2);
        chk("reset_grant",   32'(grant),   32'd0);
        chk("reset_fstep",   fstep,        32'd0);
        chk("reset_preempt", 32'(preempt), 32'd0);
        chk_en = 1'b1;
        rst = 1'b0;
        tick(2);

        // Single request, release, then confirm IDLE by the 1-cycle grant latency.
        req = 3'b100; fs[2] = 32'h1234;
        tick();
        chk("single_grant", 32'(grant), 32'h4);
        chk("single_fstep", fstep, 32'h1234);
        tick(4);
        chk("single_hold", 32'(grant), 32'h4);
        req = 3'b000;
        tick();
        chk("single_gap_grant", 32'(grant), 32'd0);
        chk("single_gap_fstep", fstep, 32'd0);
        tick(4);
        chk("single_idle", 32'(grant), 32'd0);
        req = 3'b100;
        tick();
        chk("idle_regrant", 32'(grant), 32'h4);
        drain();

        // Simultaneous: lower index wins, lower priority never preempts.
        fs[1] = 32'h11; fs[2] = 32'h22;
        req = 3'b110;
        tick();
        chk("simul_grant", 32'(grant), 32'h2);
        chk("simul_fstep", fstep, 32'h11);
        tick(12);
        chk("simul_held", 32'(grant), 32'h2);
        fs[1] = 32'h55; fs[2] = 32'h99;
        tick();
        chk("simul_fstep_follow", fstep, 32'h55);
        drain();

        // Preemption: owner 2 at t, bit 0 raised at t+2, GAP t+9..t+12.
        fs[0] = 32'hA0; fs[2] = 32'h2222;
        req = 3'b100;
        tick();                 // t
        chk("pre_grant_t", 32'(grant), 32'h4);
        tick(2);                // t+2
        req = 3'b101;
        tick(6);                // t+8
        chk("pre_grant_t8", 32'(grant), 32'h4);
        tick();                 // t+9
        chk("pre_pulse", 32'(preempt), 32'd1);
        chk("pre_gap_grant", 32'(grant), 32'd0);
        tick();                 // t+10
        chk("pre_pulse_end", 32'(preempt), 32'd0);
        tick(2);                // t+12
        chk("pre_gap_last", 32'(grant), 32'd0);
        tick();                 // t+13
        chk("pre_new_owner", 32'(grant), 32'h1);
        chk("pre_new_fstep", fstep, 32'hA0);
        drain();

        // Release and higher request in the same cycle: no preempt pulse.
        fs[1] = 32'h3131;
        req = 3'b010;
        tick(11);
        req = 3'b001;
        tick();
        chk("rel_no_preempt", 32'(preempt), 32'd0);
        chk("rel_gap", 32'(grant), 32'd0);
        tick(3);
        chk("rel_gap_last", 32'(grant), 32'd0);
        tick();
        chk("rel_then_grant0", 32'(grant), 32'h1);
        drain();

        // Request withdrawn during GAP: back to IDLE, nobody granted.
        fs[0] = 32'h77;
        req = 3'b001;
        tick(2);
        req = 3'b000;
        tick();                 // gap 1
        req = 3'b100;
        tick(2);                // gap 3
        req = 3'b000;
        tick();                 // gap 4
        tick(3);
        chk("withdraw_idle", 32'(grant), 32'd0);

        // Reset mid-OWN, then re-grant one cycle after reset drops.
        fs[1] = 32'hABCD;
        req = 3'b010;
        tick(3);
        chk("rst_own_pre", fstep, 32'hABCD);
        rst = 1'b1;
        tick();
        chk("rst_own_grant", 32'(grant), 32'd0);
        chk("rst_own_fstep", fstep, 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_regrant", 32'(grant), 32'h2);
        chk("rst_regrant_fs", fstep, 32'hABCD);

        // Reset mid-GAP: pending request arbitrated as from IDLE.
        req = 3'b000;
        tick(2);
        req = 3'b100; rst = 1'b1;
        tick();
        chk("rst_gap_grant", 32'(grant), 32'd0);
        rst = 1'b0;
        tick();
        chk("rst_gap_regrant", 32'(grant), 32'h4);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
